// File: rtl/bcd_digit_pair_collector.sv
// -----------------------------------------------------------------------------
// bcd_digit_pair_collector
//
// Collects two BCD digits (tens first, then units) from a valid/ready digit
// stream. It presents them as a single pair to a downstream BCD-to-binary
// stage through a valid/ready handshake. The block buffers one pair only: while
// a pair is presented, no new digit is accepted.
//
// Optional feature (macro BCD_PAIR_TIMEOUT_EN):
//   When the macro is defined, a tens digit is abandoned if no units digit
//   arrives within TIMEOUT_CYCLES cycles. The abandonment is reported on
//   o_timeout. When the macro is undefined, there is no counter,
//   o_timeout is tied low, and the block waits for the units digit forever.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in TENS without a units digit (2..255)
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_digit        incoming BCD digit, tens digit first
//   i_digit_valid  i_digit valid this cycle
//   o_digit_ready  block accepts a digit this cycle (low while a pair is held)
//   i_clear        synchronous abort, highest priority
//   o_D1 / o_D0    tens / units digit of the presented pair
//   o_pair_valid   o_D1/o_D0 hold a complete pair
//   i_pair_ready   downstream consumes the pair
//   o_err          one-cycle pulse: a digit in 10..15 was rejected
//   o_timeout      one-cycle pulse: partial pair dropped by timeout
// -----------------------------------------------------------------------------
module bcd_digit_pair_collector #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_digit,
  input  logic       i_digit_valid,
  output logic       o_digit_ready,
  input  logic       i_clear,
  output logic [3:0] o_D1,
  output logic [3:0] o_D0,
  output logic       o_pair_valid,
  input  logic       i_pair_ready,
  output logic       o_err,
  output logic       o_timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;  // awaiting tens digit
  localparam logic [1:0] ST_TENS = 2'd1;  // tens held, awaiting units digit
  localparam logic [1:0] ST_FULL = 2'd2;  // pair presented downstream

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       xfer;      // handshake on the digit port
  logic       accept;    // handshake with a legal BCD digit, not aborted
  logic       reject;    // handshake with an illegal digit, not aborted
  logic       expire;    // tens digit abandoned this cycle

  // The flags are decoded directly from the state register. This keeps
  // them glitch-free and clears them asynchronously with the state.
  assign o_digit_ready = (state != ST_FULL);
  assign o_pair_valid  = (state == ST_FULL);

  assign xfer   = i_digit_valid && o_digit_ready;
  assign accept = xfer && (i_digit <= 4'd9) && !i_clear;
  assign reject = xfer && (i_digit >  4'd9) && !i_clear;

`ifdef BCD_PAIR_TIMEOUT_EN
  logic [7:0] idle_cnt;

  // The last permitted cycle is the expiry cycle. A units digit that arrives
  // in that cycle still wins over the timeout.
  assign expire = (state == ST_TENS) && !accept && !i_clear &&
                  (idle_cnt == 8'(TIMEOUT_CYCLES - 1));

  // The counter is zero everywhere except while waiting in TENS.
  // Because of this, every entry to TENS starts a fresh count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_cnt <= '0;
    end else if (state == ST_TENS && !accept && !expire && !i_clear) begin
      idle_cnt <= idle_cnt + 8'd1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // NOTE: every signal of an always_comb gets a default first. If the
  // default is missing, a path with no assignment infers a latch.
  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_nxt = ST_TENS;
        ST_TENS: begin
          if (accept)      state_nxt = ST_FULL;
          else if (expire) state_nxt = ST_IDLE;
        end
        ST_FULL: if (i_pair_ready) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. As a result,
  // all registers update together from the values that existed before the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      o_D1      <= 4'd0;
      o_D0      <= 4'd0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_err     <= reject;
      o_timeout <= expire;
      // The digit registers keep their last value outside FULL.
      // Only o_pair_valid qualifies them.
      if (accept && state == ST_IDLE) o_D1 <= i_digit;
      if (accept && state == ST_TENS) o_D0 <= i_digit;
    end
  end

endmodule

// File: tb/tb_bcd_digit_pair_collector.sv
module tb_bcd_digit_pair_collector;

  localparam int T_CYC = 4;
`ifdef BCD_PAIR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i_digit;
  logic       i_digit_valid;
  logic       o_digit_ready;
  logic       i_clear;
  logic [3:0] o_D1;
  logic [3:0] o_D0;
  logic       o_pair_valid;
  logic       i_pair_ready;
  logic       o_err;
  logic       o_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_digit_pair_collector #(.TIMEOUT_CYCLES(T_CYC)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_digit       (i_digit),
    .i_digit_valid (i_digit_valid),
    .o_digit_ready (o_digit_ready),
    .i_clear       (i_clear),
    .o_D1          (o_D1),
    .o_D0          (o_D0),
    .o_pair_valid  (o_pair_valid),
    .i_pair_ready  (i_pair_ready),
    .o_err         (o_err),
    .o_timeout     (o_timeout)
  );

  typedef struct {
    logic       clr;
    logic       vld;
    logic [3:0] dig;
    logic       pr;
    logic       rdy;
    logic       pv;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic clr, input logic vld, input logic [3:0] dig,
                              input logic pr, input logic rdy, input logic pv,
                              input logic [3:0] d1, input logic [3:0] d0, input logic err);
    vec_t v;
    v.clr = clr; v.vld = vld; v.dig = dig; v.pr = pr;
    v.rdy = rdy; v.pv = pv; v.d1 = d1; v.d0 = d0; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic pv,
                            input logic [3:0] d1, input logic [3:0] d0,
                            input logic err, input logic to);
    check({tag, ".ready"},   8'(o_digit_ready), 8'(rdy));
    check({tag, ".pvalid"},  8'(o_pair_valid),  8'(pv));
    check({tag, ".d1"},      8'(o_D1),          8'(d1));
    check({tag, ".d0"},      8'(o_D0),          8'(d0));
    check({tag, ".err"},     8'(o_err),         8'(err));
    check({tag, ".timeout"}, 8'(o_timeout),     8'(to));
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass,
  // and return at the next falling edge.
  task automatic drive(input logic c, input logic v, input logic [3:0] d, input logic p);
    i_clear       = c;
    i_digit_valid = v;
    i_digit       = d;
    i_pair_ready  = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: number of digits collected, digit values, pending pulses.
  int         held;
  int         wcnt;
  logic [3:0] md1, md0;
  logic       merr, mto;

  initial begin
    rst_n = 1'b0;
    i_clear = 1'b0; i_digit_valid = 1'b0; i_digit = 4'd0; i_pair_ready = 1'b0;

    // clr vld dig pr | rdy pv d1 d0 err   (expected outputs seen before the row's edge)
    tbl.push_back(mk(0,1, 5,0, 1,0,0,0,0));  // 5 then 9, downstream ready
    tbl.push_back(mk(0,1, 9,1, 1,0,5,0,0));
    tbl.push_back(mk(0,0, 0,1, 0,1,5,9,0));  // pair valid one cycle
    tbl.push_back(mk(0,0, 0,0, 1,0,5,9,0));
    tbl.push_back(mk(0,1, 3,0, 1,0,5,9,0));  // 3, 12, 7
    tbl.push_back(mk(0,1,12,0, 1,0,3,9,0));
    tbl.push_back(mk(0,1, 7,0, 1,0,3,9,1));  // err pulse after 12
    tbl.push_back(mk(0,0, 0,1, 0,1,3,7,0));
    tbl.push_back(mk(0,0, 0,0, 1,0,3,7,0));
    tbl.push_back(mk(0,1,15,0, 1,0,3,7,0));  // illegal digit in IDLE
    tbl.push_back(mk(0,0, 0,0, 1,0,3,7,1));
    tbl.push_back(mk(0,1, 4,0, 1,0,3,7,0));  // 4,2 held under back-pressure
    tbl.push_back(mk(0,1, 2,0, 1,0,4,7,0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,1,8,0, 0,1,4,2,0));
    tbl.push_back(mk(0,1, 8,1, 0,1,4,2,0));  // handshake, 8 still refused
    tbl.push_back(mk(0,1, 8,0, 1,0,4,2,0));  // 8 taken now as tens
    tbl.push_back(mk(1,0, 0,0, 1,0,8,2,0));  // clear from TENS
    tbl.push_back(mk(0,1, 6,0, 1,0,8,2,0));  // tens 6
    tbl.push_back(mk(1,1, 1,0, 1,0,6,2,0));  // clear with units 1
    tbl.push_back(mk(0,0, 0,0, 1,0,6,2,0));
    tbl.push_back(mk(1,1,13,0, 1,0,6,2,0));  // clear masks err
    tbl.push_back(mk(0,1, 1,0, 1,0,6,2,0));  // 1 lands in tens => was IDLE
    tbl.push_back(mk(0,1, 1,0, 1,0,1,2,0));
    tbl.push_back(mk(1,0, 0,1, 0,1,1,1,0));  // clear with pair handshake
    tbl.push_back(mk(0,0, 0,0, 1,0,1,1,0));

    #12;
    check_outs("in_reset", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      check_outs(tag, tbl[i].rdy, tbl[i].pv, tbl[i].d1, tbl[i].d0, tbl[i].err, 1'b0);
      drive(tbl[i].clr, tbl[i].vld, tbl[i].dig, tbl[i].pr);
    end

    // Timeout: tens 2, then T_CYC cycles without a digit.
    drive(0, 1, 4'd2, 0);
    for (int i = 0; i < T_CYC; i++) begin
      check("to_wait.ready", 8'(o_digit_ready), 8'd1);
      check("to_wait.timeout", 8'(o_timeout), 8'd0);
      drive(0, 0, 4'd0, 0);
    end
    check("to_expire.timeout", 8'(o_timeout), 8'(TO_EN));
    check("to_expire.pvalid", 8'(o_pair_valid), 8'd0);
`ifdef BCD_PAIR_TIMEOUT_EN
    drive(0, 0, 4'd0, 0);
    check("to_pulse_width", 8'(o_timeout), 8'd0);
    drive(0, 1, 4'd2, 0);
    check("to_retens.pvalid", 8'(o_pair_valid), 8'd0);
    for (int i = 0; i < T_CYC - 1; i++) drive(0, 0, 4'd0, 0);
`endif
    drive(0, 1, 4'd5, 0);  // units on the expiry cycle (or late, without timeout)
    check_outs("to_units", 1'b0, 1'b1, 4'd2, 4'd5, 1'b0, 1'b0);
    drive(0, 0, 4'd0, 1);
    check_outs("to_drain", 1'b1, 1'b0, 4'd2, 4'd5, 1'b0, 1'b0);

    // Asynchronous reset while a 9/9 pair is presented.
    drive(0, 1, 4'd9, 0);
    drive(0, 1, 4'd9, 0);
    i_digit_valid = 1'b0;
    check_outs("full99", 1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_outs("async_rst", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("post_rst", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    held = 0; wcnt = 0; md1 = 4'd0; md0 = 4'd0; merr = 1'b0; mto = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      logic c, v, p, x, nerr, nto;
      logic [3:0] d;
      check_outs("rand", held < 2, held == 2, md1, md0, merr, mto);
      c = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 9) < 6);
      d = 4'($urandom_range(0, 15));
      p = 1'($urandom_range(0, 1));
      nerr = 1'b0;
      nto  = 1'b0;
      if (c) begin
        held = 0;
        wcnt = 0;
      end else begin
        x    = v && (held < 2);
        nerr = x && (d > 4'd9);
        if (held == 2) begin
          if (p) held = 0;
        end else if (x && d <= 4'd9) begin
          if (held == 0) begin
            md1 = d; held = 1; wcnt = 0;
          end else begin
            md0 = d; held = 2;
          end
        end else if (held == 1 && TO_EN) begin
          wcnt++;
          if (wcnt == T_CYC) begin
            held = 0; nto = 1'b1;
          end
        end
      end
      merr = nerr;
      mto  = nto;
      drive(c, v, d, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_digit_pair_collector.md
BCD_DIGIT_PAIR_COLLECTOR -- requirements
Module: bcd_digit_pair_collector

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, idle cycles allowed between tens and units digit (legal 2..255; used only with the timeout feature).
REQ-002 SHALL have port: i_clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_digit  input  4  incoming BCD digit, most significant (tens) digit first.
REQ-005 SHALL have port: i_digit_valid  input  1  i_digit is valid this cycle.
REQ-006 SHALL have port: o_digit_ready  output  1  block accepts a digit this cycle.
REQ-007 SHALL have port: i_clear  input  1  synchronous abort; discards any partial or complete pair.
REQ-008 SHALL have port: o_D1  output  4  tens digit of the presented pair.
REQ-009 SHALL have port: o_D0  output  4  units digit of the presented pair.
REQ-010 SHALL have port: o_pair_valid  output  1  o_D1/o_D0 hold a complete pair.
REQ-011 SHALL have port: i_pair_ready  input  1  downstream BCD-to-binary stage consumes the pair.
REQ-012 SHALL have port: o_err  output  1  one-cycle pulse: rejected non-BCD digit (value 10..15).
REQ-013 SHALL have port: o_timeout  output  1  one-cycle pulse: partial pair discarded by timeout.

Function
REQ-014 SHALL implement states IDLE (awaiting tens), TENS (tens held, awaiting units), FULL (pair presented).
REQ-015 SHALL drive o_digit_ready=1 in IDLE and TENS, 0 in FULL; a digit transfer occurs only when i_digit_valid && o_digit_ready.
REQ-016 SHALL, on a valid transfer (i_digit<=9) in IDLE, capture o_D1 and move to TENS on the next edge.
REQ-017 SHALL, on a valid transfer in TENS, capture o_D0 and move to FULL; o_pair_valid rises the cycle after the units transfer (one-cycle latency).
REQ-018 SHALL, on a transfer with i_digit>=10, leave state and digit registers unchanged and pulse o_err for exactly the next cycle.
REQ-019 SHALL hold o_D1, o_D0 and o_pair_valid stable in FULL until i_pair_ready=1, then return to IDLE on that edge; no same-cycle refill (single-pair buffer).
REQ-020 SHALL treat i_clear as highest priority: next state IDLE, o_pair_valid=0, no o_err/o_timeout pulse, regardless of a simultaneous transfer or pair handshake.
REQ-021 SHALL keep o_D1/o_D0 at their last captured values outside FULL; only o_pair_valid qualifies them.

Reset
REQ-022 SHALL, while i_rst_n=0, force state IDLE, o_D1=0, o_D0=0, o_pair_valid=0, o_err=0, o_timeout=0, timeout counter=0; o_digit_ready=1 after reset release.
REQ-023 SHALL, on reset assertion mid-operation (TENS or FULL), drop the partial or complete pair with no output pulse.

Configuration
REQ-024 SHALL, with macro BCD_PAIR_TIMEOUT_EN defined, count cycles in TENS without a units transfer, return to IDLE and pulse o_timeout after TIMEOUT_CYCLES such cycles; the counter restarts on each entry to TENS.
REQ-025 SHALL, when a valid units transfer coincides with the expiry cycle, accept the digit and suppress the timeout.
REQ-026 SHALL, without BCD_PAIR_TIMEOUT_EN, omit the counter, tie o_timeout to 0 and remain in TENS indefinitely.

Verification
REQ-027 SHALL cover: digits 5 then 9 with i_pair_ready=1 -> o_pair_valid for one cycle with o_D1=5, o_D0=9; state returns to IDLE.
REQ-028 SHALL cover: digits 3, 12, 7 -> o_err pulses once after 12; pair presented as o_D1=3, o_D0=7.
REQ-029 SHALL cover: pair 4,2 with i_pair_ready=0 for 5 cycles and digit 8 offered -> o_digit_ready=0, outputs hold 4/2, 8 not taken until handshake.
REQ-030 SHALL cover: tens 6 then i_clear asserted together with units 1 -> IDLE, o_pair_valid stays 0, no pulses.
REQ-031 SHALL cover (macro defined, TIMEOUT_CYCLES=4): tens 2, no digit for 4 cycles -> o_timeout pulse, IDLE; repeat with units on the expiry cycle -> pair 2/x, no timeout.
REQ-032 SHALL cover: i_rst_n pulsed low while in FULL with pair 9/9 -> all outputs 0 asynchronously, o_digit_ready=1 after release.
